// File: rtl/sd_clk_speed_ctrl_pkg.sv
// Shared definitions for the SD clock speed controller: speed codes, FSM states
// and the width of the gap/settle counter.
package sd_clk_pkg;

    localparam int CNT_W  = 8;
    localparam int N_SPD  = 5;

    localparam logic [2:0] SD_SPD_400K = 3'd0;
    localparam logic [2:0] SD_SPD_25M  = 3'd1;
    localparam logic [2:0] SD_SPD_50M  = 3'd2;
    localparam logic [2:0] SD_SPD_100M = 3'd3;
    localparam logic [2:0] SD_SPD_200M = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GATE   = 2'd1,
        ST_SETTLE = 2'd2
    } sd_clk_state_e;

endpackage

// File: rtl/sd_clk_speed_ctrl_if.sv
// Speed-change request handshake between the SD command/init controller (master)
// and the clock speed controller (slave).
interface sd_clk_speed_ctrl_if;

    logic       I_REQ_VALID;
    logic [2:0] I_REQ_SPEED;
    logic       O_REQ_READY;
    logic       O_DONE;
    logic       O_ERR;

    modport master (
        output I_REQ_VALID, I_REQ_SPEED,
        input  O_REQ_READY, O_DONE, O_ERR
    );

    modport slave (
        input  I_REQ_VALID, I_REQ_SPEED,
        output O_REQ_READY, O_DONE, O_ERR
    );

endinterface

// File: rtl/sd_clk_speed_ctrl_onehot_dec.sv
// Speed code to one-hot mux enable decoder; all-zero when blanked or for codes
// outside the table. Purely combinational, registered by the parent.
module sd_clk_onehot_dec
    import sd_clk_pkg::*;
(
    input  logic [2:0]       code,
    input  logic             blank,
    output logic [N_SPD-1:0] onehot
);

    // NOTE: every signal written in an always_comb gets a default first so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        onehot = '0;
        if (!blank) begin
            case (code)
                SD_SPD_400K: onehot = 5'b00001;
                SD_SPD_25M:  onehot = 5'b00010;
                SD_SPD_50M:  onehot = 5'b00100;
                SD_SPD_100M: onehot = 5'b01000;
                SD_SPD_200M: onehot = 5'b10000;
                default:     onehot = '0;
            endcase
        end
    end

endmodule

// File: rtl/sd_clk_speed_ctrl.sv
// Break-before-make SD clock speed controller: drops every mux enable for a gap,
// raises the new one, waits for it to settle, then reports the clock stable.
module sd_clk_speed_ctrl
    import sd_clk_pkg::*;
#(
    parameter int GAP_CYC    = 16,
    parameter int SETTLE_CYC = 64,
    parameter int MAX_SPEED  = 4
) (
    input  logic                 CLK_25M,
    input  logic                 SYS_RST,
    sd_clk_speed_ctrl_if.slave   req_if,
    output logic                 O_CLK_OK,
    output logic [2:0]           O_SPEED,
    output logic                 O_EN_400K,
    output logic                 O_EN_25M,
    output logic                 O_EN_50M,
    output logic                 O_EN_100M,
    output logic                 O_EN_200M
);

    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [2:0]       MAX_CODE    = 3'(MAX_SPEED);

    sd_clk_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       speed_q, speed_d;
    logic [2:0]       req_q, req_d;
    logic [N_SPD-1:0] en_q, en_d;
    logic             clk_ok_q, clk_ok_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             from_req_q, from_req_d;

    logic accept;
    logic in_range;
    logic same_spd;

    assign accept   = req_if.I_REQ_VALID && ready_q && (state_q == ST_IDLE);
    assign in_range = (req_if.I_REQ_SPEED <= MAX_CODE);
    assign same_spd = (req_if.I_REQ_SPEED == speed_q);

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge CLK_25M or posedge SYS_RST) begin
        if (SYS_RST) begin
            state_q    <= ST_SETTLE;
            cnt_q      <= '0;
            speed_q    <= SD_SPD_400K;
            req_q      <= SD_SPD_400K;
            en_q       <= 5'b00001;
            clk_ok_q   <= 1'b0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            from_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            speed_q    <= speed_d;
            req_q      <= req_d;
            en_q       <= en_d;
            clk_ok_q   <= clk_ok_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            err_q      <= err_d;
            from_req_q <= from_req_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept && in_range && !same_spd) state_d = ST_GATE;
            ST_GATE:   if (cnt_q == GAP_LAST)               state_d = ST_SETTLE;
            ST_SETTLE: if (cnt_q == SETTLE_LAST)            state_d = ST_IDLE;
            default:                                        state_d = ST_SETTLE;
        endcase
    end

    // Counter restarts on every state change; IDLE keeps it parked at zero.
    always_comb begin
        cnt_d      = cnt_q;
        speed_d    = speed_q;
        req_d      = req_q;
        from_req_d = from_req_q;
        if (state_d != state_q || state_q == ST_IDLE) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (accept) begin
            req_d = req_if.I_REQ_SPEED;
        end
        if (state_q == ST_GATE && state_d == ST_SETTLE) begin
            speed_d    = req_q;
            from_req_d = 1'b1;
        end
        // READY stays low on the cycle a DONE/ERR is reported.
        ready_d  = (state_q == ST_IDLE) && (state_d == ST_IDLE) && !accept;
        clk_ok_d = (state_d == ST_IDLE);
        err_d    = accept && !in_range;
        done_d   = (accept && in_range && same_spd) ||
                   (state_q == ST_SETTLE && state_d == ST_IDLE && from_req_q);
    end

    sd_clk_onehot_dec u_dec (
        .code   (speed_d),
        .blank  (state_d == ST_GATE),
        .onehot (en_d)
    );

    assign req_if.O_REQ_READY = ready_q;
    assign req_if.O_DONE      = done_q;
    assign req_if.O_ERR       = err_q;
    assign O_CLK_OK           = clk_ok_q;
    assign O_SPEED            = speed_q;
    assign O_EN_400K          = en_q[0];
    assign O_EN_25M           = en_q[1];
    assign O_EN_50M           = en_q[2];
    assign O_EN_100M          = en_q[3];
    assign O_EN_200M          = en_q[4];

endmodule

// File: tb/tb_sd_clk_speed_ctrl.sv
// Scoreboard bench for sd_clk_speed_ctrl: the driver queues expected DONE/ERR
// events, per-DUT monitors pop and compare them when the DUT reports.
module tb_sd_clk_speed_ctrl;

    localparam int GAP    = 16;
    localparam int SETTLE = 64;
    localparam int LAT    = GAP + SETTLE + 1;

    typedef struct {
        bit         is_err;
        int         cyc;
        logic [2:0] spd;
        logic       clk_ok;
    } exp_t;

    logic CLK_25M = 1'b0;
    logic SYS_RST = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    exp_t q0[$];
    exp_t q3[$];

    sd_clk_speed_ctrl_if if0 ();
    sd_clk_speed_ctrl_if if3 ();

    logic       clk_ok0, clk_ok3;
    logic [2:0] spd0, spd3;
    logic [4:0] en0, en3;

    sd_clk_speed_ctrl #(.GAP_CYC(GAP), .SETTLE_CYC(SETTLE), .MAX_SPEED(4)) dut (
        .CLK_25M   (CLK_25M),
        .SYS_RST   (SYS_RST),
        .req_if    (if0),
        .O_CLK_OK  (clk_ok0),
        .O_SPEED   (spd0),
        .O_EN_400K (en0[0]),
        .O_EN_25M  (en0[1]),
        .O_EN_50M  (en0[2]),
        .O_EN_100M (en0[3]),
        .O_EN_200M (en0[4])
    );

    sd_clk_speed_ctrl #(.GAP_CYC(GAP), .SETTLE_CYC(SETTLE), .MAX_SPEED(3)) dut3 (
        .CLK_25M   (CLK_25M),
        .SYS_RST   (SYS_RST),
        .req_if    (if3),
        .O_CLK_OK  (clk_ok3),
        .O_SPEED   (spd3),
        .O_EN_400K (en3[0]),
        .O_EN_25M  (en3[1]),
        .O_EN_50M  (en3[2]),
        .O_EN_100M (en3[3]),
        .O_EN_200M (en3[4])
    );

    always #20 CLK_25M = ~CLK_25M;
    always @(posedge CLK_25M) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Monitors: per-cycle invariants plus scoreboard pops on DONE/ERR.
    always @(negedge CLK_25M) begin
        check("dut_onehot0", 32'($onehot0(en0)), 1);
        check("dut_done_err_excl", 32'(if0.O_DONE && if0.O_ERR), 0);
        check("dut_evt_ready_excl", 32'((if0.O_DONE || if0.O_ERR) && if0.O_REQ_READY), 0);
        if (if0.O_DONE || if0.O_ERR) begin
            if (q0.size() == 0) begin
                check("dut_unexpected_evt", 32'({if0.O_ERR, if0.O_DONE}), 0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                check("dut_evt_kind_err", 32'(if0.O_ERR), 32'(e.is_err));
                check("dut_evt_cycle", 32'(cyc), 32'(e.cyc));
                check("dut_evt_speed", 32'(spd0), 32'(e.spd));
                check("dut_evt_clk_ok", 32'(clk_ok0), 32'(e.clk_ok));
            end
        end
    end

    always @(negedge CLK_25M) begin
        check("dut3_onehot0", 32'($onehot0(en3)), 1);
        if (if3.O_DONE || if3.O_ERR) begin
            if (q3.size() == 0) begin
                check("dut3_unexpected_evt", 32'({if3.O_ERR, if3.O_DONE}), 0);
            end else begin
                exp_t e;
                e = q3.pop_front();
                check("dut3_evt_kind_err", 32'(if3.O_ERR), 32'(e.is_err));
                check("dut3_evt_cycle", 32'(cyc), 32'(e.cyc));
                check("dut3_evt_speed", 32'(spd3), 32'(e.spd));
                check("dut3_evt_clk_ok", 32'(clk_ok3), 32'(e.clk_ok));
            end
        end
    end

    // Asserts reset at a negedge, releases it, and checks the post-reset settle.
    task automatic do_reset();
        SYS_RST = 1'b1;
        #1;
        check("rst_en", 32'(en0), 32'h01);
        check("rst_clk_ok", 32'(clk_ok0), 0);
        check("rst_speed", 32'(spd0), 0);
        check("rst_ready", 32'(if0.O_REQ_READY), 0);
        check("rst_done", 32'(if0.O_DONE), 0);
        check("rst_err", 32'(if0.O_ERR), 0);
        repeat (3) @(negedge CLK_25M);
        SYS_RST = 1'b0;
        for (int k = 1; k <= SETTLE; k++) begin
            @(negedge CLK_25M);
            check("settle_en400k", 32'(en0), 32'h01);
            if (k == SETTLE - 1) check("settle_clk_ok_early", 32'(clk_ok0), 0);
            if (k == SETTLE) begin
                check("settle_clk_ok", 32'(clk_ok0), 1);
                check("settle_clk_ok3", 32'(clk_ok3), 1);
            end
        end
    endtask

    // Issues one request on dut (called at a negedge); returns the cycle of acceptance.
    task automatic send(input logic [2:0] code, input bit push, input bit is_err,
                        input int lat, input logic [2:0] exp_spd, input bit hold,
                        output int acc);
        int waited;
        waited = 0;
        acc = -1;
        if0.I_REQ_SPEED = code;
        if0.I_REQ_VALID = 1'b1;
        while (!if0.O_REQ_READY && waited < 400) begin
            @(negedge CLK_25M);
            waited++;
        end
        if (!if0.O_REQ_READY) begin
            check("accept_timeout", 0, 1);
            if0.I_REQ_VALID = 1'b0;
        end else begin
            acc = cyc;
            if (push) q0.push_back('{is_err, acc + lat, exp_spd, 1'b1});
            @(negedge CLK_25M);
            if (!hold) if0.I_REQ_VALID = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int waited;
        waited = 0;
        while (!if0.O_REQ_READY && waited < 400) begin
            @(negedge CLK_25M);
            waited++;
        end
        check("idle_timeout", 32'(if0.O_REQ_READY), 1);
    endtask

    initial begin
        int a1, a2;
        if0.I_REQ_VALID = 1'b0;
        if0.I_REQ_SPEED = 3'd0;
        if3.I_REQ_VALID = 1'b0;
        if3.I_REQ_SPEED = 3'd0;

        @(negedge CLK_25M);
        do_reset();

        // 400k -> 50M: gap of exactly GAP cycles, then EN_50M.
        send(3'd2, 1, 0, LAT, 3'd2, 0, a1);
        check("gap_en_first", 32'(en0), 0);
        check("gap_clk_ok", 32'(clk_ok0), 0);
        for (int k = 2; k <= GAP; k++) begin
            @(negedge CLK_25M);
            check("gap_en", 32'(en0), 0);
        end
        @(negedge CLK_25M);
        check("new_en_50m", 32'(en0), 32'h04);
        check("new_speed", 32'(spd0), 2);
        check("settling_clk_ok", 32'(clk_ok0), 0);
        wait_idle();

        // Illegal code 7: ERR only, nothing else moves.
        send(3'd7, 1, 1, 1, 3'd2, 0, a1);
        check("err7_en", 32'(en0), 32'h04);
        check("err7_clk_ok", 32'(clk_ok0), 1);
        @(negedge CLK_25M);
        check("err7_en_after", 32'(en0), 32'h04);
        check("err7_speed_after", 32'(spd0), 2);

        // Code 4 against MAX_SPEED=3 on the second instance.
        wait (if3.O_REQ_READY == 1'b1);
        @(negedge CLK_25M);
        if3.I_REQ_SPEED = 3'd4;
        if3.I_REQ_VALID = 1'b1;
        q3.push_back('{1'b1, cyc + 1, 3'd0, 1'b1});
        @(negedge CLK_25M);
        if3.I_REQ_VALID = 1'b0;
        check("err4_en", 32'(en3), 32'h01);
        @(negedge CLK_25M);
        check("err4_clk_ok", 32'(clk_ok3), 1);
        check("err4_speed", 32'(spd3), 0);

        // Back-to-back: VALID held, 1 then 3; second accepted the cycle after DONE.
        wait_idle();
        send(3'd1, 1, 0, LAT, 3'd1, 1, a1);
        send(3'd3, 1, 0, LAT, 3'd3, 0, a2);
        check("b2b_accept_gap", 32'(a2 - a1), 32'(LAT + 1));
        wait_idle();
        check("b2b_final_en", 32'(en0), 32'h08);

        // Move to 1, then request 1 again: immediate DONE, enables stay up.
        send(3'd1, 1, 0, LAT, 3'd1, 0, a1);
        wait_idle();
        send(3'd1, 1, 0, 1, 3'd1, 0, a1);
        for (int k = 0; k < 4; k++) begin
            check("same_en", 32'(en0), 32'h02);
            check("same_clk_ok", 32'(clk_ok0), 1);
            @(negedge CLK_25M);
        end

        // Back to 400k, then reset mid-GATE of a 400k -> 200M switch.
        wait_idle();
        send(3'd0, 1, 0, LAT, 3'd0, 0, a1);
        wait_idle();
        send(3'd4, 0, 0, LAT, 3'd4, 0, a1);
        repeat (4) @(negedge CLK_25M);
        check("mid_gate_en", 32'(en0), 0);
        do_reset();
        check("post_rst_speed", 32'(spd0), 0);

        repeat (5) @(negedge CLK_25M);
        check("q0_drained", 32'(q0.size()), 0);
        check("q3_drained", 32'(q3.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
